// File: rtl/ram8_divmod_master.sv
// ram8_divmod_master: RAM8 bus master that stores x/y, divides by repeated subtraction, writes back rem/quo.
// Ports: clk, rst (async, active-high); start/x/y request; busy/done/rem/quo/div_zero status;
// mem_e/mem_addr/mem_din/mem_w/mem_r drive the RAM, mem_dout is its combinational read data.
module ram8_divmod_master #(
  parameter int WIDTH = 16,
  parameter logic [2:0] ADDR_X = 3'd0,
  parameter logic [2:0] ADDR_Y = 3'd1,
  parameter logic [2:0] ADDR_R = 3'd2,
  parameter logic [2:0] ADDR_Q = 3'd3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rem,
  output logic [WIDTH-1:0] quo,
  output logic             div_zero,
  output logic             mem_e,
  output logic [2:0]       mem_addr,
  output logic [WIDTH-1:0] mem_din,
  output logic             mem_w,
  output logic             mem_r,
  input  logic [WIDTH-1:0] mem_dout
);
  typedef enum logic [3:0] {IDLE, WR_X, WR_Y, RD_X, RD_Y, SUB, WR_R, WR_Q, DONE} state_t;
  state_t state, nxt;
  logic [WIDTH-1:0] x_r, y_r, acc, div, cnt, din_n;
  logic [2:0] addr_n;
  logic wr_n, rd_n;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = start ? WR_X : IDLE;
      WR_X: nxt = WR_Y;
      WR_Y: nxt = RD_X;
      RD_X: nxt = RD_Y;
      RD_Y: nxt = (mem_dout == '0) ? WR_R : SUB;
      SUB:  nxt = (acc >= div) ? SUB : WR_R;
      WR_R: nxt = WR_Q;
      WR_Q: nxt = DONE;
      default: nxt = IDLE;
    endcase
  end
  // Bus outputs are registered from the next state so they are valid throughout each state's cycle.
  // The WR_X data comes straight from x because x_r is loaded on the same edge.
  always_comb begin
    wr_n = nxt inside {WR_X, WR_Y, WR_R, WR_Q};
    rd_n = nxt inside {RD_X, RD_Y};
    addr_n = (nxt == WR_Y || nxt == RD_Y) ? ADDR_Y :
             (nxt == WR_R) ? ADDR_R :
             (nxt == WR_Q) ? ADDR_Q : ADDR_X;
    din_n = (nxt == WR_X) ? x :
            (nxt == WR_Y) ? y_r :
            (nxt == WR_R) ? acc :
            (nxt == WR_Q) ? cnt : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      mem_e <= 1'b0;
      mem_w <= 1'b0;
      mem_r <= 1'b0;
      mem_addr <= '0;
      mem_din <= '0;
    end else begin
      state <= nxt;
      busy <= nxt != IDLE;
      done <= nxt == DONE;
      mem_e <= wr_n | rd_n;
      mem_w <= wr_n;
      mem_r <= rd_n;
      mem_addr <= addr_n;
      mem_din <= din_n;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_r <= '0;
      y_r <= '0;
      acc <= '0;
      div <= '0;
      cnt <= '0;
      rem <= '0;
      quo <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          x_r <= x;
          y_r <= y;
          div_zero <= 1'b0;
        end
        RD_X: acc <= mem_dout;
        RD_Y: begin
          div <= mem_dout;
          cnt <= (mem_dout == '0) ? '1 : '0;
          div_zero <= mem_dout == '0;
        end
        SUB: if (acc >= div) begin
          acc <= acc - div;
          cnt <= cnt + 1'b1;
        end
        DONE: begin
          rem <= acc;
          quo <= cnt;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ram8_divmod_master.sv
// tb_ram8_divmod_master: directed self-checking bench with a behavioural RAM8 model.
module tb_ram8_divmod_master;
  logic clk = 0, rst = 1, start = 0;
  logic [15:0] x = 0, y = 0;
  logic busy, done, div_zero, mem_e, mem_w, mem_r;
  logic [15:0] rem, quo, mem_din, mem_dout;
  logic [2:0] mem_addr;
  logic [15:0] ram [8];
  int n_run = 0, n_fail = 0, edges = 0, t0 = 0, bad_wr = 0;

  ram8_divmod_master dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
    .busy(busy), .done(done), .rem(rem), .quo(quo), .div_zero(div_zero),
    .mem_e(mem_e), .mem_addr(mem_addr), .mem_din(mem_din), .mem_w(mem_w),
    .mem_r(mem_r), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    edges <= edges + 1;
    if (mem_e && mem_w) ram[mem_addr] <= mem_din;
    if (mem_e && mem_w && mem_addr > 3'd3) bad_wr <= bad_wr + 1;
  end
  assign mem_dout = (mem_e && mem_r) ? ram[mem_addr] : 16'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic go(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    x = a; y = b; start = 1;
    @(posedge clk); #1;
    t0 = edges;
    start = 0;
  endtask

  // Returns the edge number (relative to the start edge) after which done was first seen.
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 0; i < 70000 && n < 0; i++) begin
      @(posedge clk); #1;
      if (done) n = edges - t0;
    end
  endtask

  task automatic op(input string tag, input logic [15:0] a, input logic [15:0] b,
                    input logic [15:0] er, input logic [15:0] eq, input logic ez, input int en);
    int n;
    go(a, b);
    wait_done(n);
    chk({tag, " latency"}, n, en);
    @(posedge clk); #1;
    chk({tag, " done pulse"}, done, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " rem"}, rem, er);
    chk({tag, " quo"}, quo, eq);
    chk({tag, " div_zero"}, div_zero, ez);
    chk({tag, " ram_r"}, ram[2], er);
    chk({tag, " ram_q"}, ram[3], eq);
  endtask

  initial begin
    int n;
    #1;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst rem", rem, 0);
    chk("rst quo", quo, 0);
    chk("rst mem_e", mem_e, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_din", mem_din, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 0;

    op("100/7", 16'd100, 16'd7, 16'd2, 16'd14, 1'b0, 21);
    chk("100/7 ram_x", ram[0], 100);
    chk("100/7 ram_y", ram[1], 7);
    op("5/9", 16'd5, 16'd9, 16'd5, 16'd0, 1'b0, 7);
    op("9/9", 16'd9, 16'd9, 16'd0, 16'd1, 1'b0, 8);
    op("1234/0", 16'd1234, 16'd0, 16'd1234, 16'hFFFF, 1'b1, 6);

    // second start during SUB must be ignored
    go(16'd50, 16'd3);
    repeat (5) @(posedge clk);
    @(negedge clk); x = 1; y = 1; start = 1;
    @(posedge clk); #1; start = 0; x = 7; y = 7;
    wait_done(n);
    chk("50/3 latency", n, 23);
    repeat (5) @(posedge clk); #1;
    chk("50/3 rem", rem, 2);
    chk("50/3 quo", quo, 16);
    chk("50/3 busy", busy, 0);
    chk("50/3 ram_x", ram[0], 50);

    // asynchronous reset mid-SUB
    go(16'd60, 16'd4);
    repeat (7) @(posedge clk);
    #2 rst = 1;
    #1;
    chk("arst busy", busy, 0);
    chk("arst rem", rem, 0);
    chk("arst quo", quo, 0);
    chk("arst mem_e", mem_e, 0);
    chk("arst mem_w", mem_w, 0);
    repeat (2) @(posedge clk); #1;
    chk("arst ram_r", ram[2], 2);
    chk("arst ram_q", ram[3], 16);
    @(negedge clk); rst = 0;
    op("60/4", 16'd60, 16'd4, 16'd0, 16'd15, 1'b0, 22);

    op("FFFF/1", 16'hFFFF, 16'd1, 16'd0, 16'hFFFF, 1'b0, 65542);
    chk("stray writes", bad_wr, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
